// File: rtl/cedula_pkg.sv
// Shared cédula code constants, FSM state type and the one-hot sensor to code mapping.
package cedula_pkg;

  localparam logic [0:3] CODE_NONE = 4'b0000;
  localparam logic [0:3] CODE_R2   = 4'b0001;
  localparam logic [0:3] CODE_R5   = 4'b0010;
  localparam logic [0:3] CODE_R10  = 4'b0011;
  localparam logic [0:3] CODE_R20  = 4'b0100;
  localparam logic [0:3] CODE_R50  = 4'b0101;
  localparam logic [0:3] CODE_R100 = 4'b0110;
  localparam logic [0:3] CODE_R200 = 4'b0111;
  localparam logic [0:3] CODE_ERR  = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_OFFER,
    ST_RELEASE,
    ST_FAULT
  } state_t;

  // Sensor index i maps to code i+1; more than one active line is an error.
  function automatic logic [0:3] onehot_to_code(input logic [0:6] lines);
    logic [0:3] code;
    logic [2:0] hits;
    code = CODE_NONE;
    hits = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (lines[i]) begin
        hits = hits + 3'd1;
        code = 4'(i + 1);
      end
    end
    if (hits > 3'd1) code = CODE_ERR;
    return code;
  endfunction

endpackage

// File: rtl/cedula_debouncer.sv
// Two-flop synchronizer on the sensor lines plus a saturating count of cycles the synchronized pattern has held.
// stable is low in the cycle where s has just changed, so a stale count is never trusted across a change.
module cedula_debouncer #(
  parameter logic [23:0] SAT = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:6]  note_in,
  output logic [0:6]  s,
  output logic [23:0] count,
  output logic        stable
);

  logic [0:6] meta;
  logic [0:6] s_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '0;
      s      <= '0;
      s_prev <= '0;
      count  <= '0;
    end else begin
      meta   <= note_in;
      s      <= meta;
      s_prev <= s;
      if (s != s_prev) begin
        count <= '0;
      end else if (count != SAT) begin
        count <= count + 24'd1;
      end
    end
  end

  assign stable = (s == s_prev);

endmodule

// File: rtl/cedula_encoder.sv
// Debounces the banknote sensors and offers each accepted note once as a 4-bit code on valid/ready.
// Valid appears DEBOUNCE_CYCLES+2 edges after a stable press; code and valid hold while ready is low.
module cedula_encoder
  import cedula_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] STUCK_CYCLES    = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:6] note_in,
  input  logic       clear,
  output logic [0:3] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       err_stuck
);

  localparam logic [23:0] DEB_LAST   = {8'd0, DEBOUNCE_CYCLES} - 24'd1;
  localparam logic [23:0] STUCK_LAST = STUCK_CYCLES - 24'd1;

  state_t      state;
  logic [23:0] rel_cnt;
  logic [0:6]  s;
  logic [23:0] count;
  logic        stable;
  logic        settled;

  cedula_debouncer #(
    .SAT(STUCK_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .note_in(note_in),
    .s      (s),
    .count  (count),
    .stable (stable)
  );

  assign settled = stable && (count >= DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      code_out   <= CODE_NONE;
      code_valid <= 1'b0;
      err_stuck  <= 1'b0;
      rel_cnt    <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      code_valid <= 1'b0;
      if (state == ST_FAULT) begin
        code_out  <= CODE_NONE;
        err_stuck <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (s != '0) state <= ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (s == '0) begin
            state <= ST_IDLE;
          end else if (settled) begin
            state      <= ST_OFFER;
            code_out   <= onehot_to_code(s);
            code_valid <= 1'b1;
          end
        end
        ST_OFFER: begin
          if (code_ready) begin
            state      <= ST_RELEASE;
            code_valid <= 1'b0;
            rel_cnt    <= '0;
          end
        end
        ST_RELEASE: begin
          // A release seen on the limit cycle takes precedence over the stuck error.
          if (s == '0) begin
            rel_cnt <= '0;
            if (settled) state <= ST_IDLE;
          end else if (rel_cnt >= STUCK_LAST) begin
            state     <= ST_FAULT;
            err_stuck <= 1'b1;
            code_out  <= CODE_ERR;
          end else begin
            rel_cnt <= rel_cnt + 24'd1;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cedula_encoder.sv
// Directed stimulus with a scoreboard queue of expected transfer codes checked by a handshake monitor.
module tb_cedula_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       code_ready;
  logic       code_valid;
  logic       err_stuck;
  logic [0:6] note_in;
  logic [0:3] code_out;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  cedula_encoder #(
    .DEBOUNCE_CYCLES(16'd4),
    .STUCK_CYCLES   (24'd32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note_in   (note_in),
    .clear     (clear),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .err_stuck (err_stuck)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (code_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Handshake monitor: every transfer must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst && code_valid && code_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_transfer: got %b want none", code_out);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("transfer_code", 32'(code_out), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic flag;
    rst        = 1'b1;
    clear      = 1'b0;
    code_ready = 1'b1;
    note_in    = '0;
    repeat (3) tick();
    check("rst_code", 32'(code_out), 32'd0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_err", 32'(err_stuck), 32'd0);
    rst = 1'b0;
    flag = 1'b1;
    repeat (20) begin
      tick();
      if (code_valid || err_stuck || code_out != 4'b0000) flag = 1'b0;
    end
    check("idle_quiet", 32'(flag), 32'd1);

    // R$20: valid exactly one cycle after edge 6
    note_in = 7'b0001000;
    exp_q.push_back(4'b0100);
    repeat (6) tick();
    check("r20_not_yet", 32'(code_valid), 32'd0);
    tick();
    check("r20_valid_edge6", 32'(code_valid), 32'd1);
    check("r20_code", 32'(code_out), 32'h4);
    tick();
    check("r20_one_cycle", 32'(code_valid), 32'd0);
    repeat (2) tick();
    note_in = '0;
    repeat (12) tick();
    check("r20_code_kept", 32'(code_out), 32'h4);
    check("r20_idle_valid", 32'(code_valid), 32'd0);

    // R$50 with ready held low for 8 cycles
    code_ready = 1'b0;
    note_in = 7'b0000100;
    exp_q.push_back(4'b0101);
    wait_valid("r50_wait");
    flag = 1'b1;
    repeat (8) begin
      tick();
      if (!code_valid || code_out != 4'b0101) flag = 1'b0;
    end
    check("r50_hold_stable", 32'(flag), 32'd1);
    code_ready = 1'b1;
    tick();
    check("r50_valid_drop", 32'(code_valid), 32'd0);
    flag = 1'b1;
    repeat (10) begin
      tick();
      if (code_valid) flag = 1'b0;
    end
    check("r50_no_second", 32'(flag), 32'd1);
    note_in = '0;
    repeat (12) tick();

    // Glitches on R$2 never accepted, then multi-hot gives error code
    flag = 1'b1;
    note_in = 7'b1000000;
    repeat (3) begin tick(); if (code_valid) flag = 1'b0; end
    note_in = '0;
    tick();
    if (code_valid) flag = 1'b0;
    note_in = 7'b1000000;
    repeat (3) begin tick(); if (code_valid) flag = 1'b0; end
    note_in = 7'b1100000;
    exp_q.push_back(4'b1110);
    repeat (2) begin tick(); if (code_valid) flag = 1'b0; end
    check("glitch_no_valid", 32'(flag), 32'd1);
    wait_valid("multihot_wait");
    check("multihot_code", 32'(code_out), 32'he);
    tick();
    note_in = '0;
    repeat (12) tick();

    // Clear during OFFER drops the note but keeps the displayed code
    code_ready = 1'b0;
    note_in = 7'b0010000;
    wait_valid("r10_wait");
    clear = 1'b1;
    note_in = '0;
    tick();
    clear = 1'b0;
    check("clear_offer_valid", 32'(code_valid), 32'd0);
    check("clear_offer_code", 32'(code_out), 32'h3);
    code_ready = 1'b1;
    flag = 1'b1;
    repeat (12) begin tick(); if (code_valid) flag = 1'b0; end
    check("clear_no_transfer", 32'(flag), 32'd1);

    // Stuck R$2: error 32 cycles after RELEASE entry, cleared by clear
    note_in = 7'b1000000;
    exp_q.push_back(4'b0001);
    wait_valid("stuck_wait");
    tick();
    repeat (31) tick();
    check("stuck_not_yet", 32'(err_stuck), 32'd0);
    tick();
    check("stuck_err", 32'(err_stuck), 32'd1);
    check("stuck_code", 32'(code_out), 32'he);
    repeat (16) tick();
    note_in = '0;
    repeat (8) tick();
    check("stuck_sticky", 32'(err_stuck), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("fault_clear_err", 32'(err_stuck), 32'd0);
    check("fault_clear_code", 32'(code_out), 32'd0);
    flag = 1'b1;
    repeat (10) begin tick(); if (code_valid) flag = 1'b0; end
    check("fault_clear_idle", 32'(flag), 32'd1);

    // Reset during OFFER drops R$200, then a clean R$200 transfer
    code_ready = 1'b0;
    note_in = 7'b0000001;
    wait_valid("r200_wait");
    check("r200_offer_code", 32'(code_out), 32'h7);
    rst = 1'b1;
    note_in = '0;
    tick();
    rst = 1'b0;
    check("rst_offer_valid", 32'(code_valid), 32'd0);
    check("rst_offer_code", 32'(code_out), 32'd0);
    repeat (10) tick();
    code_ready = 1'b1;
    note_in = 7'b0000001;
    exp_q.push_back(4'b0111);
    wait_valid("r200_again_wait");
    tick();
    note_in = '0;
    repeat (12) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
